conv_job_driver: RTL and testbench

Job-level initiator for the code converter core. It accepts one conversion request at a time on a valid/ready job port and drives the converter's `start`/`opcode` and its four data inputs. It waits for `done`, captures the matching output field, and returns it on a valid/ready result port. It sits between a bus or command front-end and the converter, so upstream logic never sequences converter handshakes directly.

---
 rtl/conv_job_driver_if.sv | 51 +++++
 rtl/conv_job_driver.sv | 156 +++++++++++++++
 tb/tb_conv_job_driver.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_job_driver_if.sv
// Job, converter and result signal bundle for conv_job_driver.
// master = the driver, slave = the surrounding front-end / converter.
interface conv_job_driver_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  localparam int BW = 4 * DIGITS;
  localparam int DW = (WIDTH > BW) ? WIDTH : BW;

  logic          job_valid;
  logic          job_ready;
  logic [2:0]    job_op;
  logic [DW-1:0] job_data;

  logic             cv_start;
  logic [2:0]       cv_opcode;
  logic [WIDTH-1:0] cv_bin_in;
  logic [WIDTH-1:0] cv_gray_in;
  logic [BW-1:0]    cv_bcd_in;
  logic [BW-1:0]    cv_ex3_in;
  logic [WIDTH-1:0] cv_bin_out;
  logic [WIDTH-1:0] cv_gray_out;
  logic [BW-1:0]    cv_bcd_out;
  logic [BW-1:0]    cv_ex3_out;
  logic             cv_busy;
  logic             cv_done;

  logic          res_valid;
  logic          res_ready;
  logic [2:0]    res_op;
  logic [DW-1:0] res_data;
  logic          res_err;

  modport master (
    input  job_valid, job_op, job_data,
    output job_ready,
    output cv_start, cv_opcode, cv_bin_in, cv_gray_in, cv_bcd_in, cv_ex3_in,
    input  cv_bin_out, cv_gray_out, cv_bcd_out, cv_ex3_out, cv_busy, cv_done,
    output res_valid, res_op, res_data, res_err,
    input  res_ready
  );

  modport slave (
    output job_valid, job_op, job_data,
    input  job_ready,
    input  cv_start, cv_opcode, cv_bin_in, cv_gray_in, cv_bcd_in, cv_ex3_in,
    output cv_bin_out, cv_gray_out, cv_bcd_out, cv_ex3_out, cv_busy, cv_done,
    input  res_valid, res_op, res_data, res_err,
    output res_ready
  );
endinterface

// File: rtl/conv_job_driver.sv
// Single-job initiator for the code converter core: job port -> converter -> result port.
// Optional WAIT watchdog compiled in with CONV_JOB_DRIVER_TIMEOUT_EN.
module conv_job_driver #(
  parameter int WIDTH   = 8,
  parameter int DIGITS  = 3,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  conv_job_driver_if.master bus
);
  localparam int BW = 4 * DIGITS;
  localparam int DW = (WIDTH > BW) ? WIDTH : BW;

  localparam logic [2:0] OP_B2G = 3'd0;
  localparam logic [2:0] OP_G2B = 3'd1;
  localparam logic [2:0] OP_B2D = 3'd2;
  localparam logic [2:0] OP_D2B = 3'd3;
  localparam logic [2:0] OP_D2X = 3'd4;
  localparam logic [2:0] OP_X2D = 3'd5;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAP, HOLD} state_t;

  state_t           state;
  logic             job_ready;
  logic             cv_start;
  logic [2:0]       cv_opcode;
  logic [WIDTH-1:0] cv_bin_in;
  logic [WIDTH-1:0] cv_gray_in;
  logic [BW-1:0]    cv_bcd_in;
  logic [BW-1:0]    cv_ex3_in;
  logic             res_valid;
  logic [2:0]       res_op;
  logic [DW-1:0]    res_data;
  logic             res_err;

  logic accept;
  logic illegal;
  assign accept  = bus.job_valid & job_ready;
  assign illegal = (bus.job_op > OP_X2D);

`ifdef CONV_JOB_DRIVER_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] timer;
  logic          expired;
  assign expired = (timer == TW'(TIMEOUT - 1));
`endif

  // cv_busy is observed by the converter's own status path only.
  logic unused;
  assign unused = bus.cv_busy ^ (TIMEOUT > 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      job_ready  <= 1'b0;
      cv_start   <= 1'b0;
      cv_opcode  <= '0;
      cv_bin_in  <= '0;
      cv_gray_in <= '0;
      cv_bcd_in  <= '0;
      cv_ex3_in  <= '0;
      res_valid  <= 1'b0;
      res_op     <= '0;
      res_data   <= '0;
      res_err    <= 1'b0;
`ifdef CONV_JOB_DRIVER_TIMEOUT_EN
      timer      <= '0;
`endif
    end else begin
      cv_start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            job_ready <= 1'b0;
            res_op    <= bus.job_op;
            if (illegal) begin
              // Converter is never touched; its inputs keep their last values.
              res_err   <= 1'b1;
              res_data  <= '0;
              res_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              cv_opcode  <= bus.job_op;
              cv_bin_in  <= (bus.job_op == OP_B2G || bus.job_op == OP_B2D)
                            ? bus.job_data[WIDTH-1:0] : '0;
              cv_gray_in <= (bus.job_op == OP_G2B) ? bus.job_data[WIDTH-1:0] : '0;
              cv_bcd_in  <= (bus.job_op == OP_D2B || bus.job_op == OP_D2X)
                            ? bus.job_data[BW-1:0] : '0;
              cv_ex3_in  <= (bus.job_op == OP_X2D) ? bus.job_data[BW-1:0] : '0;
              cv_start   <= 1'b1;
              state      <= ISSUE;
            end
          end else begin
            job_ready <= 1'b1;
          end
        end
        ISSUE: begin
`ifdef CONV_JOB_DRIVER_TIMEOUT_EN
          timer <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          // done takes priority over a watchdog expiring in the same cycle
          if (bus.cv_done) begin
            state <= CAP;
`ifdef CONV_JOB_DRIVER_TIMEOUT_EN
          end else if (expired) begin
            res_err   <= 1'b1;
            res_data  <= '0;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            timer <= timer + 1'b1;
`endif
          end
        end
        CAP: begin
          // One cycle after done, so the converter's output registers are settled.
          case (cv_opcode)
            OP_B2G:         res_data <= DW'(bus.cv_gray_out);
            OP_G2B, OP_D2B: res_data <= DW'(bus.cv_bin_out);
            OP_B2D, OP_X2D: res_data <= DW'(bus.cv_bcd_out);
            OP_D2X:         res_data <= DW'(bus.cv_ex3_out);
            default:        res_data <= '0;
          endcase
          res_err   <= 1'b0;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.job_ready  = job_ready;
  assign bus.cv_start   = cv_start;
  assign bus.cv_opcode  = cv_opcode;
  assign bus.cv_bin_in  = cv_bin_in;
  assign bus.cv_gray_in = cv_gray_in;
  assign bus.cv_bcd_in  = cv_bcd_in;
  assign bus.cv_ex3_in  = cv_ex3_in;
  assign bus.res_valid  = res_valid;
  assign bus.res_op     = res_op;
  assign bus.res_data   = res_data;
  assign bus.res_err    = res_err;

endmodule

// File: tb/tb_conv_job_driver.sv
// Directed bench for conv_job_driver with a small behavioural converter model.
// Watchdog checks follow CONV_JOB_DRIVER_TIMEOUT_EN.
module tb_conv_job_driver;
  localparam int WIDTH   = 8;
  localparam int DIGITS  = 3;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_job_driver_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  conv_job_driver #(.WIDTH(WIDTH), .DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  wire [61:0] outs = {bus.job_ready, bus.cv_start, bus.cv_opcode, bus.cv_bin_in,
                      bus.cv_gray_in, bus.cv_bcd_in, bus.cv_ex3_in, bus.res_valid,
                      bus.res_op, bus.res_data, bus.res_err};

  // ---------------- converter model ----------------
  function automatic logic [7:0] b2g(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] r;
    r[7] = g[7];
    for (int i = 6; i >= 0; i--) r[i] = r[i+1] ^ g[i];
    return r;
  endfunction
  function automatic logic [11:0] bin2bcd(input logic [7:0] b);
    int v;
    v = int'(b);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  function automatic logic [7:0] bcd2bin(input logic [11:0] d);
    return 8'(int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]));
  endfunction
  function automatic logic [11:0] d2x(input logic [11:0] d);
    return {d[11:8] + 4'd3, d[7:4] + 4'd3, d[3:0] + 4'd3};
  endfunction
  function automatic logic [11:0] x2d(input logic [11:0] x);
    return {x[11:8] - 4'd3, x[7:4] - 4'd3, x[3:0] - 4'd3};
  endfunction

  int   model_lat = 1;   // 0 = never signal done
  logic kick = 1'b0;
  int   cnt = 0;
  int   start_cnt = 0;
  logic fire;
  assign fire = (bus.cv_start && model_lat == 1) || kick || (cnt == 1);

  always @(posedge clk) begin
    if (!rst_n) begin
      cnt             <= 0;
      bus.cv_done     <= 1'b0;
      bus.cv_busy     <= 1'b0;
      bus.cv_bin_out  <= '0;
      bus.cv_gray_out <= '0;
      bus.cv_bcd_out  <= '0;
      bus.cv_ex3_out  <= '0;
    end else begin
      bus.cv_done <= fire;
      if (bus.cv_start) cnt <= (model_lat > 1) ? model_lat - 1 : 0;
      else if (cnt != 0) cnt <= cnt - 1;
      bus.cv_busy <= bus.cv_start ? 1'b1 : (fire ? 1'b0 : bus.cv_busy);
      if (fire) begin
        bus.cv_gray_out <= (bus.cv_opcode == 3'd0) ? b2g(bus.cv_bin_in) : 8'hC3;
        bus.cv_bin_out  <= (bus.cv_opcode == 3'd1) ? g2b(bus.cv_gray_in) :
                           (bus.cv_opcode == 3'd3) ? bcd2bin(bus.cv_bcd_in) : 8'h5A;
        bus.cv_bcd_out  <= (bus.cv_opcode == 3'd2) ? bin2bcd(bus.cv_bin_in) :
                           (bus.cv_opcode == 3'd5) ? x2d(bus.cv_ex3_in) : 12'hDDD;
        bus.cv_ex3_out  <= (bus.cv_opcode == 3'd4) ? d2x(bus.cv_bcd_in) : 12'hBBB;
      end
    end
  end

  always @(posedge clk) if (bus.cv_start) start_cnt <= start_cnt + 1;

  // ---------------- stimulus helpers ----------------
  task automatic accept(input logic [2:0] op, input logic [11:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.job_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 64'(bus.job_ready), 64'd1);
    bus.job_valid = 1'b1;
    bus.job_op    = op;
    bus.job_data  = d;
    @(negedge clk);          // cycle 1 after the accept edge
    bus.job_valid = 1'b0;
  endtask

  // Called in cycle 1; returns cycle numbers of res_valid and last cv_done seen.
  task automatic wait_res(output int vcyc, output int dcyc, input int limit);
    int n;
    n = 1;
    dcyc = -1;
    while (!bus.res_valid && n < limit) begin
      if (bus.cv_done) dcyc = n;
      @(negedge clk);
      n++;
    end
    vcyc = bus.res_valid ? n : -1;
    chk("res_valid_bound", 64'(bus.res_valid), 64'd1);
  endtask

  task automatic release_res();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("release_valid", 64'(bus.res_valid), 64'd0);
    chk("release_job_ready", 64'(bus.job_ready), 64'd1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [11:0] data;
    int          lat;
    logic [11:0] exp_data;
    logic        exp_err;
    logic [7:0]  e_bin;
    logic [7:0]  e_gray;
    logic [11:0] e_bcd;
    logic [11:0] e_ex3;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int vc, dc, s0, seen;
    vecs[0]  = '{3'd0, 12'h0B5, 1,  12'h0EF, 1'b0, 8'hB5, 8'h00, 12'h000, 12'h000};
    vecs[1]  = '{3'd2, 12'h0FF, 10, 12'h255, 1'b0, 8'hFF, 8'h00, 12'h000, 12'h000};
    vecs[2]  = '{3'd4, 12'h479, 3,  12'h7AC, 1'b0, 8'h00, 8'h00, 12'h479, 12'h000};
    vecs[3]  = '{3'd1, 12'h0EF, 2,  12'h0B5, 1'b0, 8'h00, 8'hEF, 12'h000, 12'h000};
    vecs[4]  = '{3'd3, 12'h123, 4,  12'h07B, 1'b0, 8'h00, 8'h00, 12'h123, 12'h000};
    vecs[5]  = '{3'd5, 12'h7AC, 1,  12'h479, 1'b0, 8'h00, 8'h00, 12'h000, 12'h7AC};
    vecs[6]  = '{3'd0, 12'hF80, 2,  12'h0C0, 1'b0, 8'h80, 8'h00, 12'h000, 12'h000};
    vecs[7]  = '{3'd2, 12'h000, 1,  12'h000, 1'b0, 8'h00, 8'h00, 12'h000, 12'h000};
    vecs[8]  = '{3'd7, 12'h123, 1,  12'h000, 1'b1, 8'h00, 8'h00, 12'h000, 12'h000};
    vecs[9]  = '{3'd6, 12'hFFF, 1,  12'h000, 1'b1, 8'h00, 8'h00, 12'h000, 12'h000};
    vecs[10] = '{3'd1, 12'h080, 1,  12'h0FF, 1'b0, 8'h00, 8'h80, 12'h000, 12'h000};

    rst_n         = 1'b0;
    bus.job_valid = 1'b0;
    bus.job_op    = '0;
    bus.job_data  = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(outs), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_release_job_ready", 64'(bus.job_ready), 64'd1);

    for (int i = 0; i < 11; i++) begin
      model_lat = vecs[i].lat;
      s0 = start_cnt;
      accept(vecs[i].op, vecs[i].data);
      if (vecs[i].op > 3'd5) begin
        chk($sformatf("v%0d_ill_valid", i), 64'(bus.res_valid), 64'd1);
      end else begin
        chk($sformatf("v%0d_start", i), 64'(bus.cv_start), 64'd1);
        chk($sformatf("v%0d_route", i),
            64'({bus.cv_opcode, bus.cv_bin_in, bus.cv_gray_in, bus.cv_bcd_in, bus.cv_ex3_in}),
            64'({vecs[i].op, vecs[i].e_bin, vecs[i].e_gray, vecs[i].e_bcd, vecs[i].e_ex3}));
        wait_res(vc, dc, 60);
        chk($sformatf("v%0d_valid_cycle", i), 64'(vc), 64'(vecs[i].lat + 3));
        chk($sformatf("v%0d_done_to_valid", i), 64'(vc - dc), 64'd2);
      end
      chk($sformatf("v%0d_data", i), 64'(bus.res_data), 64'(vecs[i].exp_data));
      chk($sformatf("v%0d_err", i), 64'(bus.res_err), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_op", i), 64'(bus.res_op), 64'(vecs[i].op));
      release_res();
      chk($sformatf("v%0d_start_count", i), 64'(start_cnt - s0),
          (vecs[i].op > 3'd5) ? 64'd0 : 64'd1);
    end

    // Backpressure: result must sit still while res_ready stays low.
    model_lat = 2;
    accept(3'd2, 12'h099);
    wait_res(vc, dc, 20);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold_stable_%0d", k),
          64'({bus.res_valid, bus.job_ready, bus.res_err, bus.res_op, bus.res_data}),
          64'({1'b1, 1'b0, 1'b0, 3'd2, 12'h153}));
      @(negedge clk);
    end
    release_res();

`ifdef CONV_JOB_DRIVER_TIMEOUT_EN
    model_lat = 0;
    accept(3'd0, 12'h0B5);
    wait_res(vc, dc, 40);
    chk("timeout_cycle", 64'(vc), 64'(TIMEOUT + 2));
    chk("timeout_err", 64'(bus.res_err), 64'd1);
    chk("timeout_data", 64'(bus.res_data), 64'd0);
    release_res();
    // done arriving on the very last watchdog cycle still succeeds
    model_lat = TIMEOUT;
    accept(3'd0, 12'h0B5);
    wait_res(vc, dc, 40);
    chk("edge_done_cycle", 64'(vc), 64'(TIMEOUT + 3));
    chk("edge_done_err", 64'(bus.res_err), 64'd0);
    chk("edge_done_data", 64'(bus.res_data), 64'h0EF);
    release_res();
`else
    model_lat = 0;
    accept(3'd0, 12'h0B5);
    seen = 0;
    repeat (30) begin
      if (bus.res_valid) seen = 1;
      @(negedge clk);
    end
    chk("no_watchdog_valid", 64'(seen), 64'd0);
    kick = 1'b1;
    @(negedge clk);
    kick = 1'b0;
    wait_res(vc, dc, 10);
    chk("late_done_cycle", 64'(vc), 64'd3);
    chk("late_done_err", 64'(bus.res_err), 64'd0);
    chk("late_done_data", 64'(bus.res_data), 64'h0EF);
    release_res();
`endif

    // Reset while waiting on the converter.
    model_lat = 0;
    accept(3'd2, 12'h0FF);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("wait_reset_outputs", 64'(outs), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("wait_reset_job_ready", 64'(bus.job_ready), 64'd1);
    chk("wait_reset_valid", 64'(bus.res_valid), 64'd0);

    // Driver is usable again after the mid-job reset.
    model_lat = 1;
    accept(3'd0, 12'h0B5);
    wait_res(vc, dc, 20);
    chk("post_reset_data", 64'(bus.res_data), 64'h0EF);
    release_res();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
